// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions used by the store path.
// Holds the store type codes, the narrower FSM encoding and small decode helpers.
package mcpu_pkg;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  typedef enum logic [1:0] {
    SN_IDLE  = 2'd0,
    SN_WRITE = 2'd1,
    SN_FIN   = 2'd2,
    SN_ERR   = 2'd3
  } sn_state_t;

  // A store is legal only when its type is defined and the address is naturally aligned.
  function automatic logic st_legal(input logic [1:0] st_type, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (st_type)
      ST_SB:   ok = 1'b1;
      ST_SH:   ok = (addr_lo[0] == 1'b0);
      ST_SW:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the final byte lane for a given store type.
  function automatic logic [1:0] st_last(input logic [1:0] st_type);
    logic [1:0] last;
    last = 2'd0;
    case (st_type)
      ST_SH:   last = 2'd1;
      ST_SW:   last = 2'd3;
      default: last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/st_byte_sel.sv
// Combinational 32-to-8 byte lane selector, little-endian lane numbering.
// Shared between the store narrower and the load-side assembler.
module st_byte_sel (
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  byte_out
);

  logic [7:0] lanes [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = word[8*gi +: 8];
    end
  endgenerate

  assign byte_out = lanes[idx];

endmodule

// File: rtl/store_narrower.sv
// Multi-cycle store path: narrows a 32-bit SB/SH/SW store onto an 8-bit memory port,
// one byte per accepted beat, with done/misalign completion pulses.
module store_narrower
  import mcpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready
);

  sn_state_t         state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic [1:0]        last_reg, last_next;
  logic [ADDR_W-1:0] beat_addr_reg, beat_addr_next;
  logic [31:0]       wdata_reg, wdata_next;

  logic [7:0]        lane_byte;
  logic              start_legal;

  assign start_legal = st_legal(st_type, addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SN_IDLE;
      idx_reg       <= 2'd0;
      last_reg      <= 2'd0;
      beat_addr_reg <= '0;
      wdata_reg     <= 32'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      last_reg      <= last_next;
      beat_addr_reg <= beat_addr_next;
      wdata_reg     <= wdata_next;
    end
  end

  // The beat address register doubles as the base+idx adder, so wrap-around is free.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    last_next      = last_reg;
    beat_addr_next = beat_addr_reg;
    wdata_next     = wdata_reg;
    case (state_reg)
      SN_IDLE: begin
        if (start) begin
          if (start_legal) begin
            state_next     = SN_WRITE;
            idx_next       = 2'd0;
            last_next      = st_last(st_type);
            beat_addr_next = addr;
            wdata_next     = wdata;
          end else begin
            state_next = SN_ERR;
          end
        end
      end
      SN_WRITE: begin
        if (mem_ready) begin
          if (idx_reg == last_reg) begin
            state_next = SN_FIN;
          end else begin
            idx_next       = idx_reg + 2'd1;
            beat_addr_next = beat_addr_reg + ADDR_W'(1);
          end
        end
      end
      SN_FIN:  state_next = SN_IDLE;
      SN_ERR:  state_next = SN_IDLE;
      default: state_next = SN_IDLE;
    endcase
  end

  st_byte_sel u_byte_sel (
    .word     (wdata_reg),
    .idx      (idx_reg),
    .byte_out (lane_byte)
  );

  // Memory-side outputs are forced to zero outside WRITE so the port idles quietly.
  always_comb begin
    busy      = (state_reg != SN_IDLE);
    done      = (state_reg == SN_FIN) || (state_reg == SN_ERR);
    misalign  = (state_reg == SN_ERR);
    mem_we    = (state_reg == SN_WRITE);
    mem_addr  = mem_we ? beat_addr_reg : '0;
    mem_wdata = mem_we ? lane_byte : 8'd0;
  end

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: directed test-plan stores plus randomized
// stores checked cycle by cycle against a byte-list reference model.
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  st_type = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misalign, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_narrower #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .st_type   (st_type),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_we"},   32'(mem_we), 32'd0);
  endtask

  // stall_mode: 0 = ready always, 1 = random ready, 2 = first beat stalled 3 cycles.
  // poke: throw random start pulses while busy and one in the done cycle.
  // rst_beat: assert reset while beat rst_beat is presented (-1 = never).
  task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int stall_mode, input bit poke, input int rst_beat);
    bit          legal;
    int          n, i, cyc, stalls, first_stall;
    bit          rdy;
    logic [31:0] exp_addr, exp_byte;

    legal = (t == 2'b00) || (t == 2'b01 && a[0] == 1'b0) || (t == 2'b10 && a[1:0] == 2'b00);
    n = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;

    @(negedge clk);
    start = 1'b1; st_type = t; addr = a; wdata = d; mem_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0; st_type = 2'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 1;

    if (!legal) begin
      check_eq("err_busy", 32'(busy), 32'd1);
      check_eq("err_done", 32'(done), 32'd1);
      check_eq("err_misalign", 32'(misalign), 32'd1);
      check_eq("err_we", 32'(mem_we), 32'd0);
      start = poke;
      @(negedge clk);
      start = 1'b0;
      check_idle("err_after");
      check_eq("err_after_mis", 32'(misalign), 32'd0);
      $display("txn type=%0d addr=%h data=%h illegal done_cycle=1", t, a, d);
      return;
    end

    i = 0; stalls = 0; first_stall = 0;
    while (i < n && cyc < 64) begin
      exp_addr = a + 32'(i);
      exp_byte = (d >> (8 * i)) & 32'hFF;
      check_eq("beat_we", 32'(mem_we), 32'd1);
      check_eq("beat_busy", 32'(busy), 32'd1);
      check_eq("beat_done", 32'(done), 32'd0);
      check_eq("beat_addr", mem_addr, exp_addr);
      check_eq("beat_data", 32'(mem_wdata), exp_byte);
      if (rst_beat == i) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_abort");
        @(negedge clk);
        check_idle("rst_after");
        $display("txn type=%0d addr=%h data=%h aborted_at_beat=%0d", t, a, d, i);
        return;
      end
      case (stall_mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(i == 0 && first_stall < 3);
      endcase
      if (!rdy && i == 0) first_stall++;
      mem_ready = rdy;
      start = poke ? 1'($urandom) : 1'b0;
      st_type = 2'($urandom); addr = $urandom; wdata = $urandom;
      if (rdy) i++; else stalls++;
      @(negedge clk);
      cyc++;
    end
    check_eq("beat_count", 32'(i), 32'(n));
    check_eq("fin_done", 32'(done), 32'd1);
    check_eq("fin_misalign", 32'(misalign), 32'd0);
    check_eq("fin_we", 32'(mem_we), 32'd0);
    check_eq("fin_busy", 32'(busy), 32'd1);
    check_eq("done_cycle", 32'(cyc), 32'(n + 1 + stalls));
    start = poke;
    mem_ready = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check_idle("fin_after");
    $display("txn type=%0d addr=%h data=%h beats=%0d stalls=%0d done_cycle=%0d",
             t, a, d, n, stalls, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;

    run_store(2'b10, 32'h0000_0100, 32'hAABB_CCDD, 0, 1'b0, -1);
    run_store(2'b00, 32'h0000_0007, 32'h1234_5678, 0, 1'b0, -1);
    run_store(2'b01, 32'h0000_0002, 32'h0000_BEEF, 2, 1'b0, -1);
    run_store(2'b10, 32'h0000_0102, 32'hDEAD_BEEF, 0, 1'b0, -1);
    run_store(2'b01, 32'h0000_0001, 32'hDEAD_BEEF, 0, 1'b0, -1);
    run_store(2'b11, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, -1);
    run_store(2'b10, 32'h0000_0200, 32'h0102_0304, 0, 1'b0, 1);
    run_store(2'b10, 32'h0000_0300, 32'h5566_7788, 1, 1'b1, -1);
    run_store(2'b10, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 1'b0, -1);
    run_store(2'b00, 32'hFFFF_FFFF, 32'h0000_00A5, 0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      run_store(2'($urandom), ra, $urandom, 1, 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
